// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared ALU: round-robin grant, operand capture,
// registered result/zero flag and a one-cycle done pulse back to the granted requester.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [2:0]       op0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [2:0]       op1,
   output logic [WIDTH-1:0] z,
   output logic             ex,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic [15:0]      ops_cnt
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             win;
   logic             win_nxt;
   logic             last_served;
   logic [WIDTH-1:0] la;
   logic [WIDTH-1:0] lb;
   logic [2:0]       lop;
   logic [WIDTH-1:0] alu_z;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = EXEC;
         EXEC:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      done0 = (state == DONE) && !win;
      done1 = (state == DONE) &&  win;
   end

   // On a tie the requester that was not served last wins; otherwise whoever asks.
   always_comb begin
      if (req0 && req1) win_nxt = ~last_served;
      else              win_nxt = req1;
   end

   always_comb begin
      case (lop)
         3'b000:  alu_z = la & lb;
         3'b001:  alu_z = la | lb;
         3'b010:  alu_z = la + lb;
         3'b110:  alu_z = la - lb;
         default: alu_z = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win         <= 1'b0;
         last_served <= 1'b1;
         la          <= '0;
         lb          <= '0;
         lop         <= '0;
         z           <= '0;
         ex          <= 1'b0;
         ops_cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               win <= win_nxt;
               la  <= win_nxt ? a1  : a0;
               lb  <= win_nxt ? b1  : b0;
               lop <= win_nxt ? op1 : op0;
            end
            EXEC: begin
               z  <= alu_z;
               ex <= (alu_z == '0);
            end
            DONE: begin
               last_served <= win;
               ops_cnt     <= ops_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
